// File: rtl/led_stretch.sv
// led_stretch: board-level LED output stage placed after the MD5 core.
// The core's match and activity strobes may be only a few clocks wide. This
// block stretches each one to a human-visible length. It also drives a
// free-running heartbeat LED and keeps a saturating count of matches for debug.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   match_in      raw match strobe from the MD5 core
//   act_in        raw activity strobes, one per LED channel
//   match_led_out stretched match LED (sticky until reset when MATCH_LATCH=1)
//   led_out       stretched activity LEDs
//   heartbeat_led square wave at HEARTBEAT_HZ
//   match_count   saturating count of match_in rising edges
module led_stretch #(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned NUM_LEDS      = 4,
    parameter int unsigned HOLD_MS       = 50,
    parameter int unsigned HEARTBEAT_HZ  = 1,
    parameter int unsigned MATCH_LATCH   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                match_in,
    input  logic [NUM_LEDS-1:0] act_in,
    output logic                match_led_out,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                heartbeat_led,
    output logic [15:0]         match_count
);

    localparam int unsigned HOLD_CYCLES = CLK_FREQUENCY / 1000 * HOLD_MS;
    localparam int unsigned HB_HALF     = (HEARTBEAT_HZ == 0) ? 0
                                        : CLK_FREQUENCY / (2 * HEARTBEAT_HZ);
    // The match strobe is carried as the top channel, above the activity strobes.
    localparam int unsigned NCH = NUM_LEDS + 1;
    localparam int unsigned M   = NUM_LEDS;
    localparam int unsigned CW  = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int unsigned HW  = (HB_HALF < 2) ? 1 : $clog2(HB_HALF);

    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HB_LAST  = HW'(HB_HALF - 1);

    if (HOLD_CYCLES < 1 || HB_HALF < 1 || NUM_LEDS < 1) begin : g_param_check
        $error("led_stretch: HOLD_CYCLES, HB_HALF and NUM_LEDS must all be >= 1");
    end

    logic [NCH-1:0] in_q;
    logic           match_prev_q;
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic [NCH-1:0] stretch_nxt;
    logic           sticky_q;
    logic           sticky_nxt;
    logic [HW-1:0]  hb_cnt;

    // The output for a channel is in_q OR (current count nonzero). This keeps
    // the LED on for HOLD_CYCLES full cycles after in_q falls. A single-cycle
    // strobe therefore gives a HOLD_CYCLES+1 pulse.
    always_comb begin
        cnt_nxt     = cnt;
        stretch_nxt = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (in_q[ch]) begin
                cnt_nxt[ch] = HOLD_VAL;
            end else if (cnt[ch] != '0) begin
                cnt_nxt[ch] = cnt[ch] - CW'(1);
            end
            stretch_nxt[ch] = in_q[ch] | (cnt[ch] != '0);
        end
        sticky_nxt = sticky_q | ((MATCH_LATCH != 0) & in_q[M]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q          <= '0;
            match_prev_q  <= 1'b0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                cnt[ch] <= '0;
            end
            sticky_q      <= 1'b0;
            led_out       <= '0;
            match_led_out <= 1'b0;
            match_count   <= '0;
            hb_cnt        <= '0;
            heartbeat_led <= 1'b0;
        end else begin
            in_q          <= {match_in, act_in};
            match_prev_q  <= in_q[M];
            cnt           <= cnt_nxt;
            sticky_q      <= sticky_nxt;
            led_out       <= stretch_nxt[NUM_LEDS-1:0];
            match_led_out <= stretch_nxt[M] | sticky_nxt;

            // A level held high counts once. The count holds at all-ones
            // instead of wrapping.
            if (in_q[M] && !match_prev_q && match_count != '1) begin
                match_count <= match_count + 16'd1;
            end

            if (hb_cnt == HB_LAST) begin
                hb_cnt        <= '0;
                heartbeat_led <= ~heartbeat_led;
            end else begin
                hb_cnt <= hb_cnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_stretch.sv
// Self-checking bench for led_stretch.
// With CLK_FREQUENCY=10_000, HOLD_MS=1 and HEARTBEAT_HZ=1000, the derived
// values are HOLD_CYCLES=10 and HB_HALF=5.
// Cycle t is the clock period that follows posedge t. Cycle 0 is the first
// period after the last reset edge. Inputs that are driven in cycle t are
// sampled at posedge t+1. Outputs are read at the negedge inside each cycle.
module tb_led_stretch;

    localparam int unsigned NL = 4;

    logic          clk = 1'b0;
    logic          reset, reset_l;
    logic          match_in, match_l;
    logic [NL-1:0] act_in, act_l;
    logic          match_led_out, mled_l;
    logic [NL-1:0] led_out, led_l;
    logic          heartbeat_led, hb_l;
    logic [15:0]   match_count, count_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_stretch #(
        .CLK_FREQUENCY(10_000),
        .NUM_LEDS     (NL),
        .HOLD_MS      (1),
        .HEARTBEAT_HZ (1000),
        .MATCH_LATCH  (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .match_in     (match_in),
        .act_in       (act_in),
        .match_led_out(match_led_out),
        .led_out      (led_out),
        .heartbeat_led(heartbeat_led),
        .match_count  (match_count)
    );

    led_stretch #(
        .CLK_FREQUENCY(10_000),
        .NUM_LEDS     (NL),
        .HOLD_MS      (1),
        .HEARTBEAT_HZ (1000),
        .MATCH_LATCH  (1)
    ) dut_l (
        .clk          (clk),
        .reset        (reset_l),
        .match_in     (match_l),
        .act_in       (act_l),
        .match_led_out(mled_l),
        .led_out      (led_l),
        .heartbeat_led(hb_l),
        .match_count  (count_l)
    );

    typedef struct {
        int unsigned   t;
        logic          match;
        logic [NL-1:0] act;
    } stim_t;

    typedef struct {
        int unsigned   t;
        logic [NL-1:0] led;
        logic          mled;
        logic [15:0]   cnt;
    } exp_t;

    stim_t stim [9];
    exp_t  expv [8];

    task automatic check(input string name, input int t,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, got, want);
        end
    endtask

    // Holds both DUTs in reset across one rising edge and returns during
    // cycle 0 with reset still asserted. The caller releases it.
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        reset_l  = 1'b1;
        match_in = 1'b0;
        match_l  = 1'b0;
        act_in   = '0;
        act_l    = '0;
        @(negedge clk);
    endtask

    initial begin
        int unsigned si, ei;

        // The stimulus entries hold their values from cycle t onward.
        stim = '{
            '{ 0, 1'b0, 4'b0000},
            '{10, 1'b1, 4'b0000},
            '{20, 1'b1, 4'b0011},
            '{21, 1'b1, 4'b0000},
            '{27, 1'b1, 4'b0010},
            '{28, 1'b1, 4'b0000},
            '{30, 1'b0, 4'b0000},
            '{50, 1'b1, 4'b0000},
            '{51, 1'b0, 4'b0000}
        };
        // Each expected entry applies from cycle t onward. The table covers
        // led0 22..32, led1 22..39, match LED 12..41 and 52..62, and the
        // match count stepping to 1 at 12 and to 2 at 52.
        expv = '{
            '{ 0, 4'b0000, 1'b0, 16'd0},
            '{12, 4'b0000, 1'b1, 16'd1},
            '{22, 4'b0011, 1'b1, 16'd1},
            '{33, 4'b0010, 1'b1, 16'd1},
            '{40, 4'b0000, 1'b1, 16'd1},
            '{42, 4'b0000, 1'b0, 16'd1},
            '{52, 4'b0000, 1'b1, 16'd2},
            '{63, 4'b0000, 1'b0, 16'd2}
        };

        // Single pulse, retrigger, held level plus count, and heartbeat
        do_reset();
        reset   = 1'b0;
        reset_l = 1'b0;
        si = 0;
        ei = 0;
        for (int t = 0; t <= 70; t++) begin
            while (ei + 1 < 8 && expv[ei+1].t <= t) ei++;
            while (si + 1 < 9 && stim[si+1].t <= t) si++;
            check("led_out", t, 32'(led_out), 32'(expv[ei].led));
            check("match_led_out", t, 32'(match_led_out), 32'(expv[ei].mled));
            check("match_count", t, 32'(match_count), 32'(expv[ei].cnt));
            check("heartbeat", t, 32'(heartbeat_led), 32'((t / 5) % 2));
            match_in = stim[si].match;
            act_in   = stim[si].act;
            @(negedge clk);
        end

        // Reset arrives in the middle of a stretch, then the heartbeat restarts
        do_reset();
        reset   = 1'b0;
        reset_l = 1'b0;
        for (int t = 0; t <= 50; t++) begin
            check("rst_led_out", t, 32'(led_out), (t >= 22 && t <= 25) ? 32'd1 : 32'd0);
            check("rst_match_led", t, 32'(match_led_out), 32'd0);
            check("rst_heartbeat", t, 32'(heartbeat_led),
                  (t <= 25) ? 32'((t / 5) % 2) : 32'(((t - 26) / 5) % 2));
            act_in = (t == 20) ? 4'b0001 : 4'b0000;
            reset  = (t == 25);
            @(negedge clk);
        end
        check("rst_match_count", 51, 32'(match_count), 32'd0);

        // Latching match LED, cleared only by reset
        do_reset();
        reset   = 1'b0;
        reset_l = 1'b0;
        for (int t = 0; t <= 110; t++) begin
            check("latch_match_led", t, 32'(mled_l), (t >= 12 && t <= 100) ? 32'd1 : 32'd0);
            check("latch_count", t, 32'(count_l), (t >= 12 && t <= 100) ? 32'd1 : 32'd0);
            check("latch_led_out", t, 32'(led_l), 32'd0);
            check("latch_heartbeat", t, 32'(hb_l),
                  (t <= 100) ? 32'((t / 5) % 2) : 32'(((t - 101) / 5) % 2));
            match_l = (t == 10);
            reset_l = (t == 100);
            @(negedge clk);
        end

        // Saturation of match_count
        do_reset();
        reset   = 1'b0;
        reset_l = 1'b0;
        for (int n = 1; n <= 65540; n++) begin
            match_in = 1'b1;
            @(negedge clk);
            match_in = 1'b0;
            @(negedge clk);
            if (n == 1 || n == 65534 || n == 65535 || n == 65540) begin
                check("sat_count", n, 32'(match_count), (n >= 65535) ? 32'hFFFF : 32'(n));
            end
        end
        match_in = 1'b1;
        repeat (10) @(negedge clk);
        check("sat_hold", 0, 32'(match_count), 32'hFFFF);
        match_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
